// File: rtl/alu_reg.sv
// alu_reg: 32-bit integer ALU with registered result, zero and overflow flags.
// Supports ADD, SUB, AND and OR. Each accepted op shows up one clock later.
// Optional feature: define ALU_CARRY_OUT_EN to add the registered carry/no-borrow output C.

module alu_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [1:0]       Aluc,
    output logic             out_valid,
    output logic [WIDTH-1:0] R,
    output logic             Z,
`ifdef ALU_CARRY_OUT_EN
    output logic             V,
    output logic             C
`else
    output logic             V
`endif
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic [WIDTH-1:0] res_next;
    logic             zero_next;
    logic             ovf_next;
`ifdef ALU_CARRY_OUT_EN
    logic             carry_next;
`endif

    // Combinational datapath: result and flags for the op presented this cycle
    always_comb begin
        res_next  = '0;
        ovf_next  = 1'b0;
`ifdef ALU_CARRY_OUT_EN
        carry_next = 1'b0;
`endif
        case (Aluc)
            OP_ADD: begin
`ifdef ALU_CARRY_OUT_EN
                {carry_next, res_next} = {1'b0, X} + {1'b0, Y};
`else
                res_next = X + Y;
`endif
                ovf_next = (X[WIDTH-1] == Y[WIDTH-1]) && (res_next[WIDTH-1] != X[WIDTH-1]);
            end
            OP_SUB: begin
`ifdef ALU_CARRY_OUT_EN
                {carry_next, res_next} = {1'b0, X} + {1'b0, ~Y} + {{WIDTH{1'b0}}, 1'b1};
`else
                res_next = X + ~Y + {{(WIDTH-1){1'b0}}, 1'b1};
`endif
                ovf_next = (X[WIDTH-1] != Y[WIDTH-1]) && (res_next[WIDTH-1] != X[WIDTH-1]);
            end
            OP_AND: begin
                res_next = X & Y;
            end
            OP_OR: begin
                res_next = X | Y;
            end
            default: begin
                res_next = '0;
            end
        endcase
        zero_next = (res_next == '0);
    end

    // Output registers: capture on accepted ops, hold otherwise; valid pulses per accepted op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            R         <= '0;
            Z         <= 1'b0;
            V         <= 1'b0;
`ifdef ALU_CARRY_OUT_EN
            C         <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                R <= res_next;
                Z <= zero_next;
                V <= ovf_next;
`ifdef ALU_CARRY_OUT_EN
                C <= carry_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_reg.sv
// tb_alu_reg: directed self-checking bench for alu_reg.
// Covers ALU_CARRY_OUT_EN checks on C when that macro is defined.

module tb_alu_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] X;
    logic [31:0] Y;
    logic [1:0]  Aluc;
    logic        out_valid;
    logic [31:0] R;
    logic        Z;
    logic        V;
`ifdef ALU_CARRY_OUT_EN
    logic        C;
`endif

    int testCount = 0;
    int failCount = 0;

    alu_reg #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .X         (X),
        .Y         (Y),
        .Aluc      (Aluc),
        .out_valid (out_valid),
        .R         (R),
        .Z         (Z),
`ifdef ALU_CARRY_OUT_EN
        .V         (V),
        .C         (C)
`else
        .V         (V)
`endif
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs at the falling edge, then sample just after the rising edge
    task automatic applyStimulus(input logic v, input logic [31:0] x, input logic [31:0] y,
                                 input logic [1:0] op);
        @(negedge clk);
        in_valid = v;
        X        = x;
        Y        = y;
        Aluc     = op;
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the hand-computed expectation
    task automatic checkOutput(input string tag, input logic expOv, input logic [31:0] expR,
                               input logic expZ, input logic expV, input logic expC);
        testCount++;
        assert (out_valid === expOv) else begin
            failCount++;
            $error("[TB] FAIL %s out_valid: got %b expected %b", tag, out_valid, expOv);
        end
        testCount++;
        assert (R === expR) else begin
            failCount++;
            $error("[TB] FAIL %s R: got %h expected %h", tag, R, expR);
        end
        testCount++;
        assert (Z === expZ) else begin
            failCount++;
            $error("[TB] FAIL %s Z: got %b expected %b", tag, Z, expZ);
        end
        testCount++;
        assert (V === expV) else begin
            failCount++;
            $error("[TB] FAIL %s V: got %b expected %b", tag, V, expV);
        end
`ifdef ALU_CARRY_OUT_EN
        testCount++;
        assert (C === expC) else begin
            failCount++;
            $error("[TB] FAIL %s C: got %b expected %b", tag, C, expC);
        end
`else
        if (expC === 1'bx) $display("[TB] note: unexpected X in carry expectation for %s", tag);
`endif
    endtask

    // Directed test sequence
    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        X        = '0;
        Y        = '0;
        Aluc     = 2'b00;
        #12;
        checkOutput("reset_initial", 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        // Basic ops
        applyStimulus(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b00);
        checkOutput("basic_add", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b01);
        checkOutput("basic_sub", 1'b1, 32'hE1E1_E1E1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10);
        checkOutput("basic_and", 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b11);
        checkOutput("basic_or", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Overflow and wrap boundaries
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 2'b00);
        checkOutput("ovf_add", 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0001, 2'b01);
        checkOutput("ovf_sub", 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
        checkOutput("wrap_add", 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Hold: one valid op, then idle cycles with random inputs
        applyStimulus(1'b1, 32'h0000_0005, 32'h0000_0003, 2'b00);
        checkOutput("hold_setup", 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)));
            checkOutput($sformatf("hold_%0d", i), 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        end

        // Back-to-back valid ops
        applyStimulus(1'b1, 32'h0000_0001, 32'h0000_0002, 2'b01);
        checkOutput("b2b_sub_borrow", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0005, 32'h0000_0003, 2'b01);
        checkOutput("b2b_sub_noborrow", 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h1234_5678, 32'hFF00_FF00, 2'b10);
        checkOutput("b2b_and", 1'b1, 32'h1200_5600, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0000, 32'h0000_0000, 2'b11);
        checkOutput("b2b_or_zero", 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

        // Nonzero result ahead of the asynchronous reset
        applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 2'b00);
        checkOutput("pre_reset", 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_0001, 32'h0000_0001, 2'b00);
        checkOutput("pre_reset2", 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

        // Mid-cycle reset with an op in flight: clears at once, discards the op
        @(negedge clk);
        in_valid = 1'b1;
        X        = 32'h0000_00FF;
        Y        = 32'h0000_0001;
        Aluc     = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_release_idle", 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

        // First op after reset
        applyStimulus(1'b1, 32'h0000_0001, 32'h0000_0002, 2'b00);
        checkOutput("post_reset_add", 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0000, 32'h0000_0000, 2'b00);
        checkOutput("post_reset_idle", 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    // Safety timeout so the run always ends
    initial begin
        #20000;
        $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/alu_reg.md
Name: alu_reg

Overview:
- 32-bit integer ALU with registered outputs, used as the datapath execute stage of the team's simple CPU cores.
- Performs add, subtract, AND or OR on two 32-bit operands, selected by a 2-bit op code.
- Produces the result, a zero flag and a signed-overflow flag one clock after operands are accepted.

Parameters:
- WIDTH, 32, operand/result width in bits (spec values below assume 32).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/op valid this cycle.
- X  input  WIDTH  operand A.
- Y  input  WIDTH  operand B.
- Aluc  input  2  op select: 00 ADD, 01 SUB, 10 AND, 11 OR.
- out_valid  output  1  R/Z/V updated by the previous accepted op.
- R  output  WIDTH  registered result.
- Z  output  1  registered zero flag.
- V  output  1  registered signed-overflow flag.

Behaviour:
- Reset: rst_n low asynchronously clears R=0, Z=0, V=0, out_valid=0 (and C=0 if present), regardless of clk. All state is held cleared while rst_n is low.
- Reset release takes effect at the next rising clk edge. Reset asserted mid-operation discards any in-flight result.
- Ops:
  - ADD: R = X + Y modulo 2^WIDTH.
  - SUB: R = X - Y (X + ~Y + 1) modulo 2^WIDTH.
  - AND: R = X & Y.
  - OR: R = X | Y.
- Z = 1 iff the computed R is all zeros; valid for every op.
- V = two's-complement overflow.
  - ADD: X[msb]==Y[msb] and R[msb]!=X[msb].
  - SUB: X[msb]!=Y[msb] and R[msb]!=X[msb].
  - AND/OR: V = 0.
- Latency: exactly 1 cycle. Operands sampled at the rising edge where in_valid=1; R/Z/V/out_valid update at that same edge.
- in_valid=1 every cycle gives full throughput of one result per cycle, with no stall or backpressure.
- Edge with in_valid=0: out_valid goes 0; R, Z, V hold their last values.
- Operand or Aluc changes while in_valid=0 have no effect on outputs.
- Computation is combinational into the output registers. No multi-cycle states, no FSM.

Optional Feature:
- Macro ALU_CARRY_OUT_EN.
- Defined:
  - Adds output port C (1 bit, registered alongside R).
  - ADD: C = carry out of the msb.
  - SUB: C = 1 when no borrow (X >= Y unsigned).
  - AND/OR: C = 0.
  - Reset value 0; holds when in_valid=0.
- Undefined: port C does not exist; all other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with prior nonzero outputs -> R=0, Z=0, V=0, out_valid=0 immediately, without waiting for a clk edge.
- Basic ops with X=F0F0F0F0, Y=0F0F0F0F, in_valid=1, one op per cycle:
  - Aluc=00 -> R=FFFFFFFF, Z=0, V=0.
  - Aluc=01 -> R=E1E1E1E1, Z=0, V=0.
  - Aluc=10 -> R=00000000, Z=1, V=0.
  - Aluc=11 -> R=FFFFFFFF, Z=0, V=0.
  - Each result appears one cycle after its operands.
- Overflow:
  - ADD 7FFFFFFF+00000001 -> R=80000000, V=1, Z=0.
  - SUB 80000000-00000001 -> R=7FFFFFFF, V=1.
  - ADD FFFFFFFF+00000001 -> R=0, Z=1, V=0 (C=1 if ALU_CARRY_OUT_EN).
- Hold: one valid op, then in_valid=0 with random X/Y/Aluc for 5 cycles -> out_valid=0, and R/Z/V unchanged.
- Back-to-back: 4 consecutive valid ops -> out_valid=1 for 4 consecutive cycles, each with the correct result in order.
- Carry/borrow (macro defined): SUB 00000001-00000002 -> R=FFFFFFFF, C=0, V=0; SUB 5-3 -> R=2, C=1.
